// File: rtl/disaster_pkg.sv
// disaster_pkg: shared FSM state, level type, sensor thresholds and disaster indices.
package disaster_pkg;
  typedef enum logic [1:0] {ST_SAFE, ST_ARMING, ST_ALARM} state_e;
  typedef logic [1:0] level_t;
  localparam int unsigned RAIN_T1 = 2;
  localparam int unsigned RAIN_T2 = 10;
  localparam int unsigned RAIN_T3 = 30;
  localparam int unsigned SEIS_T1 = 2;
  localparam int unsigned SEIS_T2 = 6;
  localparam int unsigned SEIS_T3 = 15;
  localparam int unsigned WIND_T1 = 16;
  localparam int unsigned WIND_T2 = 30;
  localparam int unsigned WIND_T3 = 60;
  localparam int unsigned SEA_T1 = 6;
  localparam int unsigned SEA_T2 = 20;
  localparam int unsigned SEA_T3 = 50;
  // Indices ascend with priority: tsunami > earthquake > cyclone > flood.
  localparam int IDX_FLOOD = 0;
  localparam int IDX_CYCLONE = 1;
  localparam int IDX_EARTHQUAKE = 2;
  localparam int IDX_TSUNAMI = 3;
  localparam int N_DIS = 4;
  function automatic level_t level_of(int unsigned v, int unsigned t1, int unsigned t2, int unsigned t3);
    return {1'b0, v >= t1} + {1'b0, v >= t2} + {1'b0, v >= t3};
  endfunction
  function automatic logic [N_DIS-1:0] top_one(logic [N_DIS-1:0] a);
    top_one = '0;
    for (int i = 0; i < N_DIS; i++) if (a[i]) top_one = N_DIS'(1) << i;
  endfunction
endpackage

// File: rtl/disaster_persist_fsm.sv
// disaster_persist_fsm: persistence-filtered alarm with minimum hold and acknowledge.
module disaster_persist_fsm
  import disaster_pkg::*;
#(
  parameter int PERSIST = 3,
  parameter int HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic cond_i,
  input  logic ack_i,
  output logic alarm_o,
  output logic enter_o
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic cond_q, cond_d;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    hold_d = hold_q;
    // Invalid cycles fall back to the last sampled condition for the ack decision.
    cond_d = valid_i ? cond_i : cond_q;
    if (state_q == ST_ALARM) begin
      hold_d = hold_q == 8'd0 ? 8'd0 : hold_q - 8'd1;
      if (ack_i && hold_q == 8'd0 && !cond_d) begin
        state_d = ST_SAFE;
        cnt_d = 4'd0;
        hold_d = 8'd0;
      end
    end else if (valid_i) begin
      cnt_d = cond_i ? cnt_q + 4'd1 : 4'd0;
      state_d = !cond_i ? ST_SAFE : cnt_d >= 4'(PERSIST) ? ST_ALARM : ST_ARMING;
      hold_d = state_d == ST_ALARM ? 8'(HOLD) : hold_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SAFE;
      cnt_q <= 4'd0;
      hold_q <= 8'd0;
      cond_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      hold_q <= hold_d;
      cond_q <= cond_d;
    end
  end
  assign alarm_o = state_q == ST_ALARM;
  assign enter_o = !rst && state_q != ST_ALARM && state_d == ST_ALARM;
endmodule

// File: rtl/disaster_alert_seq.sv
// disaster_alert_seq: classifies sensor levels into four disasters and drives alarm LEDs.
module disaster_alert_seq
  import disaster_pkg::*;
#(
  parameter int W = 7,
  parameter int PERSIST = 3,
  parameter int HOLD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_valid,
  input  logic [W-1:0] rain,
  input  logic [W-1:0] seismic,
  input  logic [W-1:0] wind,
  input  logic [W-1:0] sea,
  input  logic mode,
  input  logic ack,
  output logic flood_led,
  output logic cyclone_led,
  output logic earthquake_led,
  output logic tsunami_led,
  output logic safe_led,
  output logic danger_led,
  output logic new_alarm
);
  level_t r, s, wd, l;
  logic [N_DIS-1:0] cond, alarm, enter, lit;
  logic new_alarm_q;
  assign r = level_of(32'(rain), RAIN_T1, RAIN_T2, RAIN_T3);
  assign s = level_of(32'(seismic), SEIS_T1, SEIS_T2, SEIS_T3);
  assign wd = level_of(32'(wind), WIND_T1, WIND_T2, WIND_T3);
  assign l = level_of(32'(sea), SEA_T1, SEA_T2, SEA_T3);
  assign cond[IDX_EARTHQUAKE] = s >= 2'd1;
  assign cond[IDX_TSUNAMI] = s == 2'd3 || l >= 2'd2;
  assign cond[IDX_FLOOD] = r >= 2'd2 && (wd >= 2'd2 || l >= 2'd2 || r == 2'd3);
  assign cond[IDX_CYCLONE] = wd >= 2'd2 && (wd == 2'd3 || l >= 2'd2 || r >= 2'd2);
  for (genvar g = 0; g < N_DIS; g++) begin : g_fsm
    disaster_persist_fsm #(.PERSIST(PERSIST), .HOLD(HOLD)) u_fsm (
      .clk(clk),
      .rst(rst),
      .valid_i(sample_valid),
      .cond_i(cond[g]),
      .ack_i(ack),
      .alarm_o(alarm[g]),
      .enter_o(enter[g])
    );
  end
  always_ff @(posedge clk) new_alarm_q <= rst ? 1'b0 : |enter;
  assign lit = mode ? alarm : top_one(alarm);
  assign flood_led = lit[IDX_FLOOD];
  assign cyclone_led = lit[IDX_CYCLONE];
  assign earthquake_led = lit[IDX_EARTHQUAKE];
  assign tsunami_led = lit[IDX_TSUNAMI];
  assign danger_led = |alarm;
  assign safe_led = ~danger_led;
  assign new_alarm = new_alarm_q;
endmodule

// File: tb/tb_disaster_alert_seq.sv
// tb_disaster_alert_seq: directed scenarios plus random stimulus checked against a behavioural model.
module tb_disaster_alert_seq;
  logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0, mode = 1'b1, ack = 1'b0;
  logic [6:0] rain = '0, seismic = '0, wind = '0, sea = '0;
  logic a_fl, a_cy, a_eq, a_ts, a_safe, a_dng, a_new;
  logic b_fl, b_cy, b_eq, b_ts, b_safe, b_dng, b_new;
  int errors = 0, checks = 0;
  int m_cnt[2][4], m_hold[2][4];
  bit m_alarm[2][4], m_cond[2][4], m_new[2];
  int mp[2] = '{3, 1};
  int mh[2] = '{8, 0};

  always #5 clk = ~clk;

  disaster_alert_seq dut_a (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .rain(rain), .seismic(seismic),
    .wind(wind), .sea(sea), .mode(mode), .ack(ack), .flood_led(a_fl), .cyclone_led(a_cy),
    .earthquake_led(a_eq), .tsunami_led(a_ts), .safe_led(a_safe), .danger_led(a_dng),
    .new_alarm(a_new)
  );
  disaster_alert_seq #(.PERSIST(1), .HOLD(0)) dut_b (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .rain(rain), .seismic(seismic),
    .wind(wind), .sea(sea), .mode(mode), .ack(ack), .flood_led(b_fl), .cyclone_led(b_cy),
    .earthquake_led(b_eq), .tsunami_led(b_ts), .safe_led(b_safe), .danger_led(b_dng),
    .new_alarm(b_new)
  );

  function automatic int lvl(int v, int t1, int t2, int t3);
    return int'(v >= t1) + int'(v >= t2) + int'(v >= t3);
  endfunction

  // Index order: 0 flood, 1 cyclone, 2 earthquake, 3 tsunami.
  task automatic model_update();
    int rl, sl, wl, ll;
    bit c[4];
    bit eff;
    rl = lvl(int'(rain), 2, 10, 30);
    sl = lvl(int'(seismic), 2, 6, 15);
    wl = lvl(int'(wind), 16, 30, 60);
    ll = lvl(int'(sea), 6, 20, 50);
    c[0] = rl >= 2 && (wl >= 2 || ll >= 2 || rl == 3);
    c[1] = wl >= 2 && (wl == 3 || ll >= 2 || rl >= 2);
    c[2] = sl >= 1;
    c[3] = sl == 3 || ll >= 2;
    for (int m = 0; m < 2; m++) begin
      m_new[m] = 0;
      for (int d = 0; d < 4; d++) begin
        if (rst) begin
          m_cnt[m][d] = 0; m_hold[m][d] = 0; m_alarm[m][d] = 0; m_cond[m][d] = 0;
          continue;
        end
        eff = sample_valid ? c[d] : m_cond[m][d];
        if (m_alarm[m][d]) begin
          if (ack && m_hold[m][d] == 0 && !eff) begin
            m_alarm[m][d] = 0; m_cnt[m][d] = 0;
          end else if (m_hold[m][d] > 0) m_hold[m][d]--;
        end else if (sample_valid) begin
          m_cnt[m][d] = c[d] ? m_cnt[m][d] + 1 : 0;
          if (m_cnt[m][d] >= mp[m]) begin
            m_alarm[m][d] = 1; m_hold[m][d] = mh[m]; m_new[m] = 1;
          end
        end
        if (sample_valid) m_cond[m][d] = c[d];
      end
    end
  endtask

  function automatic logic [6:0] expect_out(int m);
    bit led[4];
    bit any;
    any = m_alarm[m][0] | m_alarm[m][1] | m_alarm[m][2] | m_alarm[m][3];
    for (int d = 0; d < 4; d++) led[d] = mode ? m_alarm[m][d] : 1'b0;
    if (!mode) begin
      if (m_alarm[m][3]) led[3] = 1;
      else if (m_alarm[m][2]) led[2] = 1;
      else if (m_alarm[m][1]) led[1] = 1;
      else if (m_alarm[m][0]) led[0] = 1;
    end
    return {led[0], led[1], led[2], led[3], ~any, any, m_new[m]};
  endfunction

  task automatic compare();
    logic [6:0] got_a, got_b, exp_a, exp_b;
    got_a = {a_fl, a_cy, a_eq, a_ts, a_safe, a_dng, a_new};
    got_b = {b_fl, b_cy, b_eq, b_ts, b_safe, b_dng, b_new};
    exp_a = expect_out(0);
    exp_b = expect_out(1);
    checks += 2;
    if (got_a !== exp_a) begin
      errors++;
      $display("FAIL outputs_default t=%0t: got %b expected %b (fl cy eq ts safe danger new)", $time, got_a, exp_a);
    end
    if (got_b !== exp_b) begin
      errors++;
      $display("FAIL outputs_p1h0 t=%0t: got %b expected %b (fl cy eq ts safe danger new)", $time, got_b, exp_b);
    end
  endtask

  task automatic chk(string name, logic got, logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1 compare();
  endtask

  task automatic drive(int ra, int se, int wi, int sa, bit v, bit a);
    rain = 7'(ra); seismic = 7'(se); wind = 7'(wi); sea = 7'(sa);
    sample_valid = v; ack = a;
    tick();
  endtask

  task automatic do_reset();
    sample_valid = 0; ack = 0; rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("reset_safe", a_safe, 1'b1);
    chk("reset_danger", a_dng, 1'b0);
    // Flood persistence
    repeat (2) drive(40, 0, 0, 0, 1, 0);
    chk("flood_not_yet", a_fl, 1'b0);
    drive(40, 0, 0, 0, 1, 0);
    chk("flood_led", a_fl, 1'b1);
    chk("flood_danger", a_dng, 1'b1);
    chk("flood_safe", a_safe, 1'b0);
    chk("flood_new", a_new, 1'b1);
    drive(40, 0, 0, 0, 0, 0);
    chk("flood_new_once", a_new, 1'b0);
    // Persistence break, then gaps that must not break it
    do_reset();
    drive(40, 0, 0, 0, 1, 0); drive(40, 0, 0, 0, 1, 0); drive(0, 0, 0, 0, 1, 0);
    drive(40, 0, 0, 0, 1, 0); drive(40, 0, 0, 0, 1, 0);
    chk("break_no_alarm", a_fl, 1'b0);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(40, 0, 0, 0, 1, 0);
      if (i < 2) repeat (5) drive(40, 0, 0, 0, 0, 0);
    end
    chk("gap_alarm", a_fl, 1'b1);
    // Priority and same-cycle mode switching
    do_reset();
    mode = 1;
    repeat (3) drive(40, 20, 70, 0, 1, 0);
    chk("multi_fl", a_fl, 1'b1); chk("multi_cy", a_cy, 1'b1);
    chk("multi_eq", a_eq, 1'b1); chk("multi_ts", a_ts, 1'b1);
    mode = 0;
    #1 compare();
    chk("unique_ts", a_ts, 1'b1); chk("unique_eq", a_eq, 1'b0); chk("unique_fl", a_fl, 1'b0);
    mode = 1;
    #1 compare();
    chk("remulti_fl", a_fl, 1'b1);
    // Acknowledge rules
    do_reset();
    repeat (3) drive(0, 0, 0, 55, 1, 0);
    chk("tsu_entry", a_ts, 1'b1);
    for (int i = 0; i <= 10; i++) begin
      drive(0, 0, 0, i == 10 ? 0 : 55, i == 8 || i == 10, i == 3 || i == 8 || i == 10);
      if (i == 3) chk("ack_hold_ignored", a_ts, 1'b1);
      if (i == 8) chk("ack_cond_ignored", a_ts, 1'b1);
      if (i == 10) chk("ack_honoured", a_ts, 1'b0);
    end
    // Reset during ARMING and during ALARM
    do_reset();
    repeat (2) drive(40, 0, 0, 0, 1, 0);
    do_reset();
    chk("rst_arming_safe", a_safe, 1'b1);
    repeat (2) drive(40, 0, 0, 0, 1, 0);
    chk("rearm_partial", a_fl, 1'b0);
    drive(40, 0, 0, 0, 1, 0);
    chk("rearm_full", a_fl, 1'b1);
    do_reset();
    chk("rst_alarm_safe", a_safe, 1'b1);
    chk("rst_alarm_led", a_fl, 1'b0);
    chk("rst_alarm_new", a_new, 1'b0);
    // PERSIST=1, HOLD=0 instance
    do_reset();
    drive(40, 0, 0, 0, 1, 0);
    chk("p1_alarm", b_fl, 1'b1);
    chk("p1_new", b_new, 1'b1);
    drive(0, 0, 0, 0, 1, 1);
    chk("h0_ack_clear", b_fl, 1'b0);
    // Random stimulus
    do_reset();
    for (int i = 0; i < 800; i++) begin
      mode = 1'($urandom_range(0, 1));
      rst = $urandom_range(0, 63) == 0;
      drive($urandom_range(0, 9) < 4 ? 0 : $urandom_range(0, 127),
            $urandom_range(0, 9) < 5 ? 0 : $urandom_range(0, 127),
            $urandom_range(0, 9) < 4 ? 0 : $urandom_range(0, 127),
            $urandom_range(0, 9) < 5 ? 0 : $urandom_range(0, 127),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
    end
    rst = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/disaster_alert_seq.md
DISASTER_ALERT_SEQ -- requirements
Module: disaster_alert_seq

Interface
REQ-001 SHALL have parameter W, default 7: width of every sensor input.
REQ-002 SHALL have parameter PERSIST, default 3, range 1..15: consecutive true valid samples needed before an alarm is raised.
REQ-003 SHALL have parameter HOLD, default 8, range 0..255: minimum cycles an alarm stays active before ack is honoured.
REQ-004 SHALL have ports, in this order:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous and active-high.
- sample_valid  in  1  sensor inputs are sampled this cycle.
- rain, seismic, wind, sea  in  W each  unsigned sensor readings.
- mode  in  1  1 = MULTI (every active alarm shown), 0 = UNIQUE (highest priority only).
- ack  in  1  operator acknowledge, level-sampled.
- flood_led, cyclone_led, earthquake_led, tsunami_led  out  1 each  alarm indicators.
- safe_led  out  1  no alarm active.
- danger_led  out  1  at least one alarm active.
- new_alarm  out  1  one-cycle pulse when any disaster enters ALARM.

Function
REQ-005 On a valid sample, each sensor SHALL get a 2-bit level equal to the number of its three thresholds met (value >= threshold). Thresholds: rain 2/10/30, seismic 2/6/15, wind 16/30/60, sea 6/20/50.
REQ-006 Conditions SHALL be computed from levels R, S, Wd, L:
- earthquake = S>=1
- tsunami = S==3 or L>=2
- flood = R>=2 and (Wd>=2 or L>=2 or R==3)
- cyclone = Wd>=2 and (Wd==3 or L>=2 or R>=2)
REQ-007 Each disaster SHALL have an independent FSM with states SAFE, ARMING, ALARM, a persistence counter (0..PERSIST) and a hold counter.
REQ-008 On a valid sample with condition true, SAFE/ARMING SHALL increment the counter and enter ALARM when it reaches PERSIST, otherwise ARMING. With PERSIST=1, SAFE goes straight to ALARM.
REQ-009 On a valid sample with condition false, ARMING SHALL return to SAFE and clear the counter; ALARM SHALL be unaffected.
REQ-010 Cycles with sample_valid=0 SHALL leave counters and states unchanged (except the hold countdown) and SHALL NOT break persistence.
REQ-011 Entering ALARM SHALL load the hold counter with HOLD. In ALARM it SHALL decrement once per cycle, saturating at 0.
REQ-012 ALARM SHALL move to SAFE, clearing both counters, only when all of these hold in the same cycle:
- ack=1
- hold counter==0
- the effective condition is false (the current sample's condition if sample_valid=1, else the last registered condition).
ack in any other cycle SHALL be ignored, with no memory of it kept.
REQ-013 LED outputs SHALL be decoded from the registered FSM states and mode:
- MULTI: every disaster in ALARM is lit.
- UNIQUE: exactly the highest-priority ALARM disaster is lit, priority tsunami > earthquake > cyclone > flood.
REQ-014 danger_led SHALL be the OR of all four ALARM states; safe_led SHALL be its inverse. ARMING SHALL NOT assert danger.
REQ-015 Latency: a valid sample at edge k SHALL be reflected in the LEDs from cycle k+1. new_alarm SHALL be high only in cycle k+1 when one or more FSMs enter ALARM at edge k. Simultaneous entries SHALL give one pulse.
REQ-016 A mode change SHALL affect the LEDs in the same cycle and SHALL NOT alter FSM state.

Reset
REQ-017 When rst=1 at a clock edge, all FSMs SHALL go to SAFE and all counters and registered conditions SHALL go to 0. rst SHALL override sample_valid and ack.
REQ-018 Outputs after reset: all four LEDs 0, danger_led 0, safe_led 1, new_alarm 0. This applies equally when reset is asserted mid-ARMING or mid-ALARM.

Structure
REQ-019 A shared package disaster_pkg SHALL hold:
- the FSM state enum
- the 2-bit level typedef
- the twelve threshold constants
- the disaster index and priority order constants.
REQ-020 The per-disaster FSM (REQ-007..012) SHALL be a sub-module disaster_persist_fsm, instantiated four times; classification and decode stay in the top level.

Verification
REQ-021 The bench SHALL cover these scenarios, with defaults unless stated:
- Flood persistence: rain=40, others 0, three consecutive valid samples -> after the 3rd, flood_led=1, danger_led=1, safe_led=0, new_alarm high for exactly 1 cycle.
- Persistence break and gaps: rain=40 ×2, rain=0 ×1, rain=40 ×2 -> no alarm. Then rain=40 valid samples separated by 5 invalid cycles, ×3 -> alarm raised.
- Priority: seismic=20, wind=70, rain=40, sea=0, PERSIST samples. mode=1 -> all four LEDs 1. mode=0 -> only tsunami_led=1, and switching back restores all four in the same cycle.
- Acknowledge: tsunami alarm from sea=55.
  - ack at entry+3 -> ignored (hold not expired).
  - ack at entry+8 with sea=55 valid -> ignored (condition true).
  - ack at entry+10 with sea=0 valid -> tsunami_led=0 next cycle.
- Reset: rst for 1 cycle during ARMING, then during ALARM -> next cycle all LEDs 0, safe_led=1; re-arming needs a full PERSIST samples.
- Edge parameters: PERSIST=1, HOLD=0 -> alarm on the first sample; same-cycle ack with a false sample clears it immediately.
